// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and helpers for the parameterised inter-stage pipeline register.
package pipe_stage_reg_pkg;

  localparam int   PIPE_MODE_STALL = 0;
  localparam int   PIPE_MODE_HS    = 1;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_HOLD
  } stall_act_e;

  // This stage stalled with the next one running means a bubble must be injected downstream.
  function automatic stall_act_e stall_decode(input logic s, input logic n);
    if (s != STOP)      return ACT_LOAD;
    else if (n != STOP) return ACT_BUBBLE;
    else                return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid storage with its full flag, used by the elastic handshake mode.
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int SIDE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic              drain,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [SIDE_W-1:0] side
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear) begin
      full <= 1'b0;
    end else if (capture) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // Payload needs no reset; it is only observed while full is set.
  always_ff @(posedge clk) begin
    if (capture && !clear) begin
      data <= in_data;
      side <= in_side;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: stall-vector control or valid/ready with a skid entry.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                SIDE_W    = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                MODE      = PIPE_MODE_STALL,
  parameter int                STALL_W   = 6,
  parameter int                STALL_IDX = 2,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SIDE_W-1:0]  in_side,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SIDE_W-1:0]  out_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic              skid_full;
  logic              adv;
  logic              bub;
  logic              cnt_inc;
  logic [DATA_W-1:0] nxt_data;
  logic [SIDE_W-1:0] nxt_side;

  // Each mode ignores some inputs; fold them here so lint sees them consumed.
  logic unused_ok;
  assign unused_ok = ^{stall, in_valid, out_ready};

  generate
    if (MODE == PIPE_MODE_HS) begin : g_hs
      logic              load;
      logic              skid_capture;
      logic              skid_drain;
      logic [DATA_W-1:0] skid_data;
      logic [SIDE_W-1:0] skid_side;

      pipe_skid_buf #(
        .DATA_W (DATA_W),
        .SIDE_W (SIDE_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .capture (skid_capture),
        .drain   (skid_drain),
        .in_data (in_data),
        .in_side (in_side),
        .full    (skid_full),
        .data    (skid_data),
        .side    (skid_side)
      );

      // in_ready is low only while the skid holds an entry, so a load never competes with upstream.
      always_comb begin
        load         = !out_valid || out_ready;
        skid_capture = in_valid && in_ready && out_valid && !out_ready;
        skid_drain   = load && skid_full;
        adv          = load && (skid_full || in_valid);
        bub          = load && !adv;
        nxt_data     = skid_full ? skid_data : in_data;
        nxt_side     = skid_full ? skid_side : in_side;
        cnt_inc      = !out_valid && out_ready;
      end
    end else begin : g_stall
      stall_act_e act;

      assign skid_full = 1'b0;

      always_comb begin
        act      = stall_decode(stall[STALL_IDX], stall[STALL_IDX+1]);
        adv      = (act == ACT_LOAD);
        bub      = (act == ACT_BUBBLE);
        cnt_inc  = bub;
        nxt_data = in_data;
        nxt_side = in_side;
      end
    end
  endgenerate

  assign in_ready = !skid_full;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      out_data   <= NOP_VALUE;
      out_side   <= '0;
      out_valid  <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      out_data  <= NOP_VALUE;
      out_valid <= 1'b0;
    end else begin
      if (adv) begin
        out_data  <= nxt_data;
        out_side  <= nxt_side;
        out_valid <= 1'b1;
      end else if (bub) begin
        out_data  <= NOP_VALUE;
        out_valid <= 1'b0;
      end
      if (cnt_inc && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: stall-vector instance, handshake instance, and a narrow-counter instance.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: stall mode, b: handshake mode, c: stall mode with 2-bit counter
  logic       a_flush, b_flush, c_flush;
  logic [5:0] a_stall, b_stall, c_stall;
  logic [7:0] a_in_data, b_in_data, c_in_data;
  logic       a_in_side, b_in_side, c_in_side;
  logic       a_in_valid, b_in_valid, c_in_valid;
  logic       a_in_ready, b_in_ready, c_in_ready;
  logic [7:0] a_out_data, b_out_data, c_out_data;
  logic       a_out_side, b_out_side, c_out_side;
  logic       a_out_valid, b_out_valid, c_out_valid;
  logic       a_out_ready, b_out_ready, c_out_ready;
  logic [15:0] a_cnt, b_cnt;
  logic [1:0]  c_cnt;

  pipe_stage_reg #(.DATA_W(8), .SIDE_W(1), .NOP_VALUE(8'h00), .MODE(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .stall(a_stall), .in_data(a_in_data),
    .in_side(a_in_side), .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_side(a_out_side), .out_valid(a_out_valid), .out_ready(a_out_ready), .bubble_cnt(a_cnt));

  pipe_stage_reg #(.DATA_W(8), .SIDE_W(1), .NOP_VALUE(8'h00), .MODE(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .stall(b_stall), .in_data(b_in_data),
    .in_side(b_in_side), .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_side(b_out_side), .out_valid(b_out_valid), .out_ready(b_out_ready), .bubble_cnt(b_cnt));

  pipe_stage_reg #(.DATA_W(8), .SIDE_W(1), .NOP_VALUE(8'h00), .MODE(0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .stall(c_stall), .in_data(c_in_data),
    .in_side(c_in_side), .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_side(c_out_side), .out_valid(c_out_valid), .out_ready(c_out_ready), .bubble_cnt(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_flush = 0; a_stall = 6'b000000; a_in_data = 8'hFF; a_in_side = 1; a_in_valid = 1; a_out_ready = 1;
    b_flush = 0; b_stall = 6'b000000; b_in_data = 8'hFF; b_in_side = 1; b_in_valid = 0; b_out_ready = 0;
    c_flush = 0; c_stall = 6'b000000; c_in_data = 8'h00; c_in_side = 0; c_in_valid = 1; c_out_ready = 1;
    rst = 1;
    tick();
    tick();
    checks++;
    if ({a_out_data, a_out_valid, a_out_side, a_cnt} !== {8'h00, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_a: got data=%h valid=%b side=%b cnt=%0d, expected 00/0/0/0",
               a_out_data, a_out_valid, a_out_side, a_cnt);
    end
    checks++;
    if ({b_out_data, b_out_valid, b_out_side, b_cnt} !== {8'h00, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_b: got data=%h valid=%b side=%b cnt=%0d, expected 00/0/0/0",
               b_out_data, b_out_valid, b_out_side, b_cnt);
    end
    rst = 0;
    a_in_side = 0;
    a_in_data = 8'hA5;
    tick();
    checks++;
    if (b_in_ready !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got b=%b a=%b, expected 1/1", b_in_ready, a_in_ready);
    end
  endtask

  task automatic test_stall_load();
    a_stall = 6'b000000; a_in_data = 8'hA5; a_in_side = 0;
    tick();
    checks++;
    if ({a_out_data, a_out_valid, a_out_side, a_cnt} !== {8'hA5, 1'b1, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL stall_load: got data=%h valid=%b side=%b cnt=%0d, expected a5/1/0/0",
               a_out_data, a_out_valid, a_out_side, a_cnt);
    end
  endtask

  task automatic test_stall_bubble();
    a_in_side = 1; a_in_data = 8'h5A; a_stall = 6'b000100;
    tick();
    checks++;
    if ({a_out_data, a_out_valid, a_out_side, a_cnt} !== {8'h00, 1'b0, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL stall_bubble: got data=%h valid=%b side=%b cnt=%0d, expected 00/0/0/1",
               a_out_data, a_out_valid, a_out_side, a_cnt);
    end
    a_stall = 6'b001100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({a_out_data, a_out_valid, a_out_side, a_cnt} !== {8'h00, 1'b0, 1'b0, 16'd1}) begin
        errors++;
        $display("FAIL stall_hold_bubble[%0d]: got data=%h valid=%b side=%b cnt=%0d, expected 00/0/0/1",
                 i, a_out_data, a_out_valid, a_out_side, a_cnt);
      end
    end
    a_stall = 6'b000000;
    tick();
    checks++;
    if ({a_out_data, a_out_valid, a_out_side} !== {8'h5A, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL stall_resume: got data=%h valid=%b side=%b, expected 5a/1/1",
               a_out_data, a_out_valid, a_out_side);
    end
    a_stall = 6'b001100; a_in_data = 8'h11; a_in_side = 0;
    tick();
    checks++;
    if ({a_out_data, a_out_valid, a_out_side, a_cnt} !== {8'h5A, 1'b1, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL stall_hold_valid: got data=%h valid=%b side=%b cnt=%0d, expected 5a/1/1/1",
               a_out_data, a_out_valid, a_out_side, a_cnt);
    end
  endtask

  task automatic test_stall_flush();
    a_flush = 1; a_stall = 6'b000000; a_in_data = 8'h3C; a_in_side = 0;
    tick();
    checks++;
    if ({a_out_data, a_out_valid, a_out_side, a_cnt} !== {8'h00, 1'b0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL stall_flush: got data=%h valid=%b side=%b cnt=%0d, expected 00/0/1/1",
               a_out_data, a_out_valid, a_out_side, a_cnt);
    end
    a_flush = 0;
    tick();
    checks++;
    if ({a_out_data, a_out_valid, a_out_side} !== {8'h3C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stall_after_flush: got data=%h valid=%b side=%b, expected 3c/1/0",
               a_out_data, a_out_valid, a_out_side);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] items [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] got [$];
    int  idx = 0;
    bit  stalled_once = 0;
    bit  fire_out, fire_in;
    logic [7:0] val;
    for (int cyc = 0; cyc < 20; cyc++) begin
      b_in_valid = (idx < 4);
      b_in_data  = (idx < 4) ? items[idx] : 8'hEE;
      b_in_side  = 0;
      b_out_ready = 1;
      if (idx == 1 && !stalled_once) begin
        b_out_ready = 0;
        stalled_once = 1;
      end
      #1;
      fire_out = b_out_valid && b_out_ready;
      fire_in  = b_in_valid && b_in_ready;
      val      = b_out_data;
      tick();
      if (fire_out) got.push_back(val);
      if (fire_in) idx++;
      if (!b_out_ready) begin
        checks++;
        if (b_in_ready !== 1'b0 || b_out_data !== 8'd1) begin
          errors++;
          $display("FAIL b2b_skid_capture: got in_ready=%b out=%h, expected 0/01", b_in_ready, b_out_data);
        end
      end
      if (got.size() == 4) break;
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d items, expected 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== items[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got %h, expected %h", i, (i < got.size()) ? got[i] : 8'hXX, items[i]);
      end
    end
    checks++;
    if ({b_out_valid, b_out_data, b_cnt} !== {1'b0, 8'h00, 16'd1}) begin
      errors++;
      $display("FAIL b2b_drained: got valid=%b data=%h cnt=%0d, expected 0/00/1", b_out_valid, b_out_data, b_cnt);
    end
    b_in_valid = 0; b_out_ready = 0;
  endtask

  task automatic test_skid_flush();
    b_in_valid = 1; b_in_data = 8'h05; b_out_ready = 1;
    tick();
    b_in_data = 8'h06; b_out_ready = 0;
    tick();
    checks++;
    if ({b_in_ready, b_out_valid, b_out_data} !== {1'b0, 1'b1, 8'h05}) begin
      errors++;
      $display("FAIL skid_full: got in_ready=%b valid=%b data=%h, expected 0/1/05", b_in_ready, b_out_valid, b_out_data);
    end
    b_flush = 1; b_in_data = 8'h07; b_out_ready = 1;
    tick();
    checks++;
    if ({b_in_ready, b_out_valid, b_out_data, b_cnt} !== {1'b1, 1'b0, 8'h00, 16'd2}) begin
      errors++;
      $display("FAIL skid_flush: got in_ready=%b valid=%b data=%h cnt=%0d, expected 1/0/00/2",
               b_in_ready, b_out_valid, b_out_data, b_cnt);
    end
    b_flush = 0; b_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL skid_flush_leak[%0d]: got valid=%b data=%h, expected valid 0", i, b_out_valid, b_out_data);
      end
    end
    checks++;
    if (b_cnt !== 16'd5) begin
      errors++;
      $display("FAIL hs_bubble_cnt: got %0d, expected 5", b_cnt);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    c_stall = 6'b000000; c_in_data = 8'h77; c_in_side = 1;
    tick();
    c_stall = 6'b000100; c_in_side = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({c_cnt, c_out_valid, c_out_side} !== {exp_cnt[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL sat_cnt[%0d]: got cnt=%0d valid=%b side=%b, expected %0d/0/1",
                 i, c_cnt, c_out_valid, c_out_side, exp_cnt[i]);
      end
    end
    rst = 1;
    tick();
    checks++;
    if ({c_out_data, c_out_valid, c_out_side, c_cnt} !== {8'h00, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL sat_reset: got data=%h valid=%b side=%b cnt=%0d, expected 00/0/0/0",
               c_out_data, c_out_valid, c_out_side, c_cnt);
    end
    checks++;
    if ({b_cnt, a_cnt, b_in_ready} !== {16'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_again: got b_cnt=%0d a_cnt=%0d b_in_ready=%b, expected 0/0/1", b_cnt, a_cnt, b_in_ready);
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_stall_load();
    test_stall_bubble();
    test_stall_flush();
    test_back_to_back();
    test_skid_flush();
    test_saturate_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
